// File: rtl/pipeline_counter_pkg.sv
// Shared encodings and geometry helpers for the banked pipelined counter array.
package pipeline_counter_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'd0,
    OP_INC      = 2'd1,
    OP_READ     = 2'd2,
    OP_READ_CLR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic int bankAw(input int addrWidth, input int numBanks);
    return addrWidth - $clog2(numBanks);
  endfunction

  function automatic int latency(input int numBanks);
    return 2 * numBanks + 1;
  endfunction

endpackage

// File: rtl/pipeline_counter_bank.sv
// One pipeline segment: a bank RAM with a read stage and a write stage, write-to-read
// forwarding for back-to-back same-index ops, and a zeroing port used by the bulk clear.
module pipeline_counter_bank
  import pipeline_counter_pkg::*;
#(
  parameter int  ADDR_WIDTH_FULL = 12,
  parameter int  DATA_WIDTH      = 32,
  parameter int  NUM_BANKS       = 4,
  parameter int  BANK_ID         = 0,
  parameter type req_t           = logic,
  localparam int BANK_AW         = bankAw(ADDR_WIDTH_FULL, NUM_BANKS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  req_t               in_i,
  input  logic               clr_en_i,
  input  logic [BANK_AW-1:0] clr_idx_i,
  output req_t               out_o,
  output logic               busy_o
);

  localparam int              BW    = $clog2(NUM_BANKS);
  localparam logic [BW-1:0]   MY_ID = BW'(BANK_ID);

  logic [DATA_WIDTH-1:0] mem_q [2**BANK_AW];
  req_t                  r_q, r_d, w_q, w_d;
  logic                  rdOwn, wrOwn, wrEn, fwdHit;
  logic [BANK_AW-1:0]    rdIdx, wrIdx;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] newVal;

  // The request sitting in the write stage lands in RAM only at the end of this
  // cycle, so a same-index read behind it must take the new value directly.
  always_comb begin
    rdIdx  = in_i.addr[BANK_AW-1:0];
    wrIdx  = r_q.addr[BANK_AW-1:0];
    rdOwn  = in_i.valid && (in_i.addr[ADDR_WIDTH_FULL-1:BANK_AW] == MY_ID);
    wrOwn  = r_q.valid && (r_q.addr[ADDR_WIDTH_FULL-1:BANK_AW] == MY_ID);
    sum    = {1'b0, r_q.old} + (DATA_WIDTH+1)'(r_q.inc);
    newVal = '0;
    wrEn   = 1'b0;
    w_d    = r_q;
    if (wrOwn) begin
      case (r_q.op)
        OP_INC: begin
          wrEn    = 1'b1;
          w_d.sat = sum[DATA_WIDTH];
          newVal  = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
        end
        OP_READ_CLR: wrEn = 1'b1;
        default: ;
      endcase
    end
    fwdHit = wrEn && (wrIdx == rdIdx);
    r_d    = in_i;
    if (rdOwn) begin
      r_d.old = fwdHit ? newVal : mem_q[rdIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_en_i) begin
      mem_q[clr_idx_i] <= '0;
    end else if (wrEn) begin
      mem_q[wrIdx] <= newVal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      w_q <= '0;
    end else begin
      r_q <= r_d;
      w_q <= w_d;
    end
  end

  assign out_o  = w_q;
  assign busy_o = r_q.valid | w_q.valid;

endmodule

// File: rtl/pipeline_counter_array.sv
// Banked pipelined counter memory with valid/ready intake and a drain-then-clear FSM.
// Optional saturation-event counter enabled by PIPELINE_COUNTER_SAT_STATS_EN.
module pipeline_counter_array
  import pipeline_counter_pkg::*;
#(
  parameter int ADDR_WIDTH_FULL = 12,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_BANKS       = 4,
  parameter int INC_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [ADDR_WIDTH_FULL-1:0] req_addr,
  input  logic [INC_WIDTH-1:0]       req_inc,
  input  logic                       clear_start,
  output logic                       clear_busy,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_op,
  output logic [ADDR_WIDTH_FULL-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic                       rsp_sat
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
  ,
  output logic [31:0]                sat_events
`endif
);

  localparam int BANK_AW = bankAw(ADDR_WIDTH_FULL, NUM_BANKS);

  // Declared here rather than in the package because its widths track this instance.
  typedef struct packed {
    logic                       valid;
    op_e                        op;
    logic [ADDR_WIDTH_FULL-1:0] addr;
    logic [INC_WIDTH-1:0]       inc;
    logic [DATA_WIDTH-1:0]      old;
    logic                       sat;
  } req_t;

  req_t                 in_q, in_d;
  req_t                 stage [NUM_BANKS+1];
  logic [NUM_BANKS-1:0] bankBusy;
  logic                 pipeBusy, clrEn;
  state_e               state_q, state_d;
  logic [BANK_AW-1:0]   clrIdx_q, clrIdx_d;

  // NOPs are accepted but never enter the pipeline, so they cannot produce a response.
  always_comb begin
    in_d.valid = req_valid && req_ready && (req_op != 2'(OP_NOP));
    in_d.op    = op_e'(req_op);
    in_d.addr  = req_addr;
    in_d.inc   = req_inc;
    in_d.old   = '0;
    in_d.sat   = 1'b0;
  end

  assign pipeBusy = in_q.valid | (|bankBusy);

  always_comb begin
    state_d    = state_q;
    clrIdx_d   = clrIdx_q;
    clrEn      = 1'b0;
    req_ready  = 1'b0;
    clear_busy = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready  = 1'b1;
        clear_busy = 1'b0;
        if (clear_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pipeBusy) begin
          state_d  = ST_CLEAR;
          clrIdx_d = '0;
        end
      end
      ST_CLEAR: begin
        clrEn    = 1'b1;
        clrIdx_d = clrIdx_q + BANK_AW'(1);
        if (clrIdx_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // RAM contents are unknown after reset, so the FSM always starts with a sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CLEAR;
      clrIdx_q <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      clrIdx_q <= clrIdx_d;
      in_q     <= in_d;
    end
  end

  assign stage[0] = in_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    pipeline_counter_bank #(
      .ADDR_WIDTH_FULL(ADDR_WIDTH_FULL),
      .DATA_WIDTH     (DATA_WIDTH),
      .NUM_BANKS      (NUM_BANKS),
      .BANK_ID        (b),
      .req_t          (req_t)
    ) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_i     (stage[b]),
      .clr_en_i (clrEn),
      .clr_idx_i(clrIdx_q),
      .out_o    (stage[b+1]),
      .busy_o   (bankBusy[b])
    );
  end

  assign rsp_valid = stage[NUM_BANKS].valid;
  assign rsp_op    = stage[NUM_BANKS].op;
  assign rsp_addr  = stage[NUM_BANKS].addr;
  assign rsp_data  = stage[NUM_BANKS].old;
  assign rsp_sat   = stage[NUM_BANKS].sat;

`ifdef PIPELINE_COUNTER_SAT_STATS_EN
  logic [31:0] satEvents_q, satEvents_d;

  always_comb begin
    satEvents_d = satEvents_q;
    if (state_q != ST_CLEAR && state_d == ST_CLEAR) begin
      satEvents_d = '0;
    end else if (rsp_valid && rsp_sat && satEvents_q != '1) begin
      satEvents_d = satEvents_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) satEvents_q <= '0;
    else        satEvents_q <= satEvents_d;
  end

  assign sat_events = satEvents_q;
`endif

endmodule

// File: tb/tb_pipeline_counter_array.sv
// Directed bench for pipeline_counter_array built with 8-bit counters so saturation is reachable.
// Checks sat_events too when PIPELINE_COUNTER_SAT_STATS_EN is defined.
module tb_pipeline_counter_array;

  localparam int LAT_EXP = 9;

  logic        clk, rst_n, req_valid, req_ready, clear_start, clear_busy;
  logic        rsp_valid, rsp_sat;
  logic [1:0]  req_op, rsp_op;
  logic [11:0] req_addr, rsp_addr;
  logic [7:0]  req_inc, rsp_data;
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
  logic [31:0] sat_events;
`endif

  typedef struct {
    int          cyc;
    logic [1:0]  op;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        sat;
  } rsp_s;

  rsp_s rspQ [$];
  int   acceptQ [$];
  int   cyc = 0;
  int   busyCnt = 0;
  int   testsRun = 0;
  int   failCount = 0;

  logic [11:0] clrAddr [6] = '{12'h123, 12'h456, 12'h000, 12'h400, 12'h800, 12'hC00};
  logic [7:0]  clrOld  [6] = '{8'd20, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
  logic        clrSat  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  pipeline_counter_array #(
    .ADDR_WIDTH_FULL(12),
    .DATA_WIDTH     (8),
    .NUM_BANKS      (4),
    .INC_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_inc    (req_inc),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .rsp_valid  (rsp_valid),
    .rsp_op     (rsp_op),
    .rsp_addr   (rsp_addr),
    .rsp_data   (rsp_data),
    .rsp_sat    (rsp_sat)
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
    ,
    .sat_events (sat_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Everything the DUT does is recorded on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && rsp_valid)
      rspQ.push_back('{cyc: cyc, op: rsp_op, addr: rsp_addr, data: rsp_data, sat: rsp_sat});
    if (rst_n && req_valid && req_ready && req_op != 2'd0)
      acceptQ.push_back(cyc);
    if (rst_n && clear_busy)
      busyCnt <= busyCnt + 1;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request for a single accepted cycle; entered and left at #1 after a posedge.
  task automatic applyStimulus(input logic [1:0] op, input logic [11:0] addr,
                               input logic [7:0] inc, input logic clr);
    int guard = 0;
    req_valid   = 1'b1;
    req_op      = op;
    req_addr    = addr;
    req_inc     = inc;
    clear_start = clr;
    while (!req_ready && guard < 2000) begin
      waitCycles(1);
      guard++;
    end
    if (!req_ready) checkOutput("readyTimeout", 64'd0, 64'd1);
    waitCycles(1);
    req_valid   = 1'b0;
    req_op      = 2'd0;
    req_inc     = '0;
    clear_start = 1'b0;
  endtask

  task automatic expectRsp(input string tag, input logic [1:0] op, input logic [11:0] addr,
                           input logic [7:0] data, input logic sat);
    int   g = 0;
    int   a;
    rsp_s r;
    while (rspQ.size() == 0 && g < 60) begin
      waitCycles(1);
      g++;
    end
    if (rspQ.size() == 0) begin
      checkOutput({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    r = rspQ.pop_front();
    checkOutput({tag, "_op"}, 64'(r.op), 64'(op));
    checkOutput({tag, "_addr"}, 64'(r.addr), 64'(addr));
    checkOutput({tag, "_data"}, 64'(r.data), 64'(data));
    checkOutput({tag, "_sat"}, 64'(r.sat), 64'(sat));
    if (acceptQ.size() != 0) begin
      a = acceptQ.pop_front();
      checkOutput({tag, "_lat"}, 64'(r.cyc - a), 64'(LAT_EXP));
    end
  endtask

  task automatic waitIdle(input string tag);
    int g = 0;
    while (clear_busy && g < 1300) begin
      waitCycles(1);
      g++;
    end
    checkOutput({tag, "_idle"}, 64'(clear_busy), 64'd0);
  endtask

  initial begin
    int n;
    int readyErr;
    int n0;
    int g;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_op      = 2'd0;
    req_addr    = '0;
    req_inc     = '0;
    clear_start = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstRspValid", 64'(rsp_valid), 64'd0);
    checkOutput("rstRspOp", 64'(rsp_op), 64'd0);
    checkOutput("rstRspAddr", 64'(rsp_addr), 64'd0);
    checkOutput("rstRspData", 64'(rsp_data), 64'd0);
    checkOutput("rstRspSat", 64'(rsp_sat), 64'd0);
    checkOutput("rstReady", 64'(req_ready), 64'd0);
    checkOutput("rstBusy", 64'(clear_busy), 64'd1);
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
    checkOutput("rstSatEvents", 64'(sat_events), 64'd0);
`endif

    // Post-reset sweep: 1024 busy cycles with req_ready held low.
    rst_n    = 1'b1;
    n        = 0;
    readyErr = 0;
    forever begin
      @(negedge clk);
      if (!clear_busy || n > 3000) break;
      n++;
      if (req_ready) readyErr++;
    end
    @(posedge clk);
    #1;
    checkOutput("initClearLen", 64'(n), 64'd1024);
    checkOutput("initClearReady", 64'(readyErr), 64'd0);
    checkOutput("idleReady", 64'(req_ready), 64'd1);

    applyStimulus(2'd2, 12'h7FF, 8'd0, 1'b0);
    expectRsp("read7ff", 2'd2, 12'h7FF, 8'd0, 1'b0);

    // Back-to-back increments through the forwarding path, then an immediate read.
    for (int i = 0; i < 4; i++) applyStimulus(2'd1, 12'h123, 8'd5, 1'b0);
    applyStimulus(2'd2, 12'h123, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) expectRsp("inc123", 2'd1, 12'h123, 8'(i * 5), 1'b0);
    expectRsp("rd123", 2'd2, 12'h123, 8'd20, 1'b0);

    // Saturation at 255, including an increment when already at maximum.
    applyStimulus(2'd1, 12'h456, 8'd200, 1'b0);
    applyStimulus(2'd1, 12'h456, 8'd200, 1'b0);
    applyStimulus(2'd2, 12'h456, 8'd0, 1'b0);
    applyStimulus(2'd1, 12'h456, 8'd1, 1'b0);
    expectRsp("sat1", 2'd1, 12'h456, 8'd0, 1'b0);
    expectRsp("sat2", 2'd1, 12'h456, 8'd200, 1'b1);
    expectRsp("satRd", 2'd2, 12'h456, 8'd255, 1'b0);
    expectRsp("satMax", 2'd1, 12'h456, 8'd255, 1'b1);
    waitCycles(2);
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
    checkOutput("satEvents", 64'(sat_events), 64'd2);
`endif

    // READ_CLR in the last bank, a NOP in the stream, and an untouched neighbour.
    applyStimulus(2'd1, 12'hC00, 8'd7, 1'b0);
    applyStimulus(2'd1, 12'hC01, 8'd3, 1'b0);
    applyStimulus(2'd0, 12'hC00, 8'd9, 1'b0);
    applyStimulus(2'd3, 12'hC00, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'hC00, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'hC01, 8'd0, 1'b0);
    expectRsp("incC00", 2'd1, 12'hC00, 8'd0, 1'b0);
    expectRsp("incC01", 2'd1, 12'hC01, 8'd0, 1'b0);
    expectRsp("rclrC00", 2'd3, 12'hC00, 8'd7, 1'b0);
    expectRsp("rdC00", 2'd2, 12'hC00, 8'd0, 1'b0);
    expectRsp("rdC01", 2'd2, 12'hC01, 8'd3, 1'b0);
    waitCycles(12);
    checkOutput("nopSilent", 64'(rspQ.size()), 64'd0);

    // Clear requested together with the last of six in-flight increments.
    busyCnt = 0;
    for (int i = 0; i < 6; i++) applyStimulus(2'd1, clrAddr[i], 8'd1, 1'(i == 5));
    checkOutput("clrReadyDrop", 64'(req_ready), 64'd0);
    checkOutput("clrBusyRise", 64'(clear_busy), 64'd1);
    for (int i = 0; i < 6; i++) expectRsp($sformatf("clrInc%0d", i), 2'd1, clrAddr[i], clrOld[i], clrSat[i]);
    waitIdle("clr");
    checkOutput("clrLenInRange", 64'((busyCnt >= 1025) && (busyCnt <= 1060)), 64'd1);
`ifdef PIPELINE_COUNTER_SAT_STATS_EN
    checkOutput("satEventsCleared", 64'(sat_events), 64'd0);
`endif
    for (int i = 0; i < 6; i++) applyStimulus(2'd2, clrAddr[i], 8'd0, 1'b0);
    for (int i = 0; i < 6; i++) expectRsp($sformatf("clrRd%0d", i), 2'd2, clrAddr[i], 8'd0, 1'b0);

    // Reset while responses are emerging: outputs drop at once and nothing stale follows.
    applyStimulus(2'd2, 12'h010, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'h410, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'h810, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'hC10, 8'd0, 1'b0);
    applyStimulus(2'd2, 12'h011, 8'd0, 1'b0);
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!rsp_valid && g < 20);
    checkOutput("midRspSeen", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(rsp_valid), 64'd0);
    checkOutput("midRstReady", 64'(req_ready), 64'd0);
    checkOutput("midRstBusy", 64'(clear_busy), 64'd1);
    n0 = rspQ.size();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycles(1);
    checkOutput("midRelBusy", 64'(clear_busy), 64'd1);
    waitIdle("midRst");
    waitCycles(20);
    checkOutput("noStaleRsp", 64'(rspQ.size()), 64'(n0));
    rspQ.delete();
    acceptQ.delete();
    applyStimulus(2'd2, 12'h123, 8'd0, 1'b0);
    expectRsp("postRstRd", 2'd2, 12'h123, 8'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
